// File: rtl/zl_uart_pkg.sv
// zl_uart_pkg: shared state encoding, frame constants and responder register map for the zl_uart link.
package zl_uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP, S_WDATA, S_STOP, S_RWAIT, S_RDATA, S_RESP
    } state_t;
    localparam int FRAME_BITS = 8;
    localparam int RW_BIT     = 0;
    localparam logic [6:0] REG_SIG_HI  = 7'd0;
    localparam logic [6:0] REG_SIG_LO  = 7'd1;
    localparam logic [6:0] REG_SCRATCH = 7'd2;
    localparam logic [6:0] REG_LED     = 7'd3;
    localparam logic [6:0] REG_INPUT   = 7'd4;
    localparam logic [15:0] SIGNATURE  = 16'hDEDA;
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic write);
        addr_byte = {addr, 1'b0};
        addr_byte[RW_BIT] = write;
    endfunction
endpackage

// File: rtl/zl_sync2.sv
// zl_sync2: two-flop synchronizer for the idle-high serial input, resets to 1.
module zl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b11;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/zl_uart_host.sv
// zl_uart_host: register-link initiator; sends address/write-data frames on tx, collects read replies from rx.
// Defining ZL_UART_HOST_RDTIMEOUT_EN adds the read-reply timeout and rsp_err.
module zl_uart_host
    import zl_uart_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int RD_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       tx,
    input  logic       rx
);
    if (GAP_CYCLES < 1 || GAP_CYCLES > 200 || RD_TIMEOUT < 2 || RD_TIMEOUT > 255) begin : g_bad_param
        $error("zl_uart_host: GAP_CYCLES or RD_TIMEOUT out of range");
    end

    state_t      state, state_n;
    logic [3:0]  bcnt;
    logic [7:0]  wcnt;
    logic [15:0] sh;
    logic        wr, rx_s, tx_n, frame_end, timeout, bit_run, wait_run;

    zl_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

    assign cmd_ready = state == S_IDLE;
    assign busy      = !cmd_ready;
    assign rsp_valid = state == S_STOP || state == S_RESP;
    assign frame_end = bcnt == 4'(FRAME_BITS);
    assign bit_run   = state == S_ADDR || state == S_WDATA || state == S_RDATA;
`ifdef ZL_UART_HOST_RDTIMEOUT_EN
    assign timeout   = wcnt == 8'(RD_TIMEOUT - 1);
    assign wait_run  = state == S_GAP || state == S_RWAIT;
`else
    assign timeout   = 1'b0;
    assign wait_run  = state == S_GAP;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = cmd_valid ? S_ADDR : S_IDLE;
            S_ADDR:  state_n = !frame_end ? S_ADDR : wr ? S_GAP : S_RWAIT;
            S_GAP:   state_n = wcnt == 8'(GAP_CYCLES - 1) ? S_WDATA : S_GAP;
            S_WDATA: state_n = frame_end ? S_STOP : S_WDATA;
            S_RWAIT: state_n = !rx_s ? S_RDATA : timeout ? S_RESP : S_RWAIT;
            S_RDATA: state_n = bcnt == 4'(FRAME_BITS - 1) ? S_RESP : S_RDATA;
            default: state_n = S_IDLE;
        endcase
    end

    // Start bits are launched one cycle ahead so tx stays a pure register.
    assign tx_n = (state == S_IDLE && cmd_valid) || (state == S_GAP && state_n == S_WDATA) ? 1'b0 :
                  (state == S_ADDR || state == S_WDATA) && !frame_end ? sh[15] : 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx        <= 1'b1;
            bcnt      <= '0;
            wcnt      <= '0;
            sh        <= '0;
            wr        <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            tx   <= tx_n;
            bcnt <= state_n != state ? 4'd0 : bcnt + 4'(bit_run);
            wcnt <= state_n != state ? 8'd0 : wcnt + 8'(wait_run);
            if (state == S_IDLE && cmd_valid) begin
                sh <= {addr_byte(cmd_addr, cmd_write), cmd_wdata};
                wr <= cmd_write;
            end else if ((state == S_ADDR || state == S_WDATA) && !frame_end)
                sh <= {sh[14:0], 1'b0};
            else if (state == S_RDATA)
                sh[7:0] <= {sh[6:0], rx_s};
            if (state_n == S_STOP || state_n == S_RESP)
                rsp_rdata <= state == S_RDATA ? {sh[6:0], rx_s} : 8'd0;
        end

`ifdef ZL_UART_HOST_RDTIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rsp_err <= 1'b0;
        else if (state_n == S_STOP || state_n == S_RESP) rsp_err <= state == S_RWAIT;
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_zl_uart_host.sv
// tb_zl_uart_host: randomized command traffic checked every cycle against a frame-level model of the link.
module tb_zl_uart_host;
    localparam int G = 2;
    localparam int T = 32;
`ifdef ZL_UART_HOST_RDTIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 0, rst_n = 0, cmd_valid = 0, cmd_write = 0, rx = 1;
    logic [6:0] cmd_addr = 0;
    logic [7:0] cmd_wdata = 0;
    logic       cmd_ready, rsp_valid, rsp_err, busy, tx;
    logic [7:0] rsp_rdata;

    zl_uart_host #(.GAP_CYCLES(G), .RD_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int rsp_cyc = -1, n_rsp = 0;
    logic [7:0] rsp_d;
    logic rsp_e;
    logic rxh [0:65535];
    logic txh [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected line activity: one entry per future cycle; kind 1 = write done, 2 = read reply, 3 = timeout.
    typedef struct { logic t; int kind; int s; } ent_t;
    ent_t plan[$];
    bit   rd_after = 0, waiting = 0;
    int   widx = 0;
    logic [7:0] e_rd = 0;

    function automatic ent_t mk(input logic t, input int kind, input int s);
        mk.t = t; mk.kind = kind; mk.s = s;
    endfunction

    function automatic logic rs(input int t);
        return t < 2 ? 1'b1 : rxh[t-2];
    endfunction

    function automatic logic [7:0] rdbits(input int s);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[7-i] = rs(s + 1 + i);
        return d;
    endfunction

    always @(negedge clk) begin
        logic e_tx, e_rv, e_err, e_busy;
        logic [7:0] ab;
        ent_t e;
        rxh[cyc] = rst_n ? rx : 1'b1;
        txh[cyc] = tx;
        if (!rst_n) begin
            plan.delete(); rd_after = 0; waiting = 0; e_rd = 0;
            chk("rst_tx", tx, 1); chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0); chk("rst_ready", cmd_ready, 1); chk("rst_rdata", rsp_rdata, 0);
        end else begin
            e_tx = 1; e_rv = 0; e_err = 0;
            e_busy = plan.size() > 0 || waiting;
            if (plan.size() > 0) begin
                e = plan.pop_front();
                e_tx = e.t;
                if (e.kind != 0) begin
                    e_rv = 1;
                    e_rd = e.kind == 2 ? rdbits(e.s) : 8'd0;
                    e_err = e.kind == 3;
                end
                if (plan.size() == 0 && rd_after) begin rd_after = 0; waiting = 1; widx = 0; end
            end else if (waiting) begin
                if (!rs(cyc)) begin
                    waiting = 0;
                    repeat (8) plan.push_back(mk(1, 0, 0));
                    plan.push_back(mk(1, 2, cyc));
                end else if (TO_EN && widx == T - 1) begin
                    waiting = 0;
                    plan.push_back(mk(1, 3, 0));
                end else widx++;
            end else if (cmd_valid) begin
                ab = {cmd_addr, cmd_write};
                plan.push_back(mk(0, 0, 0));
                for (int i = 7; i >= 0; i--) plan.push_back(mk(ab[i], 0, 0));
                if (cmd_write) begin
                    repeat (G) plan.push_back(mk(1, 0, 0));
                    plan.push_back(mk(0, 0, 0));
                    for (int i = 7; i >= 0; i--) plan.push_back(mk(cmd_wdata[i], 0, 0));
                    plan.push_back(mk(1, 1, 0));
                end else rd_after = 1;
            end
            chk("tx", tx, e_tx);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("busy", busy, e_busy);
            chk("cmd_ready", cmd_ready, !e_busy);
            chk("rsp_rdata", rsp_rdata, e_rd);
            if (e_rv) chk("rsp_err", rsp_err, e_err);
            if (rsp_valid) begin rsp_cyc = cyc; rsp_d = rsp_rdata; rsp_e = rsp_err; n_rsp++; end
        end
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d, output int n);
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = -1;
        for (int k = 0; k < 3000 && n < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) n = cyc;
        end
        if (n < 0) chk("accept_bound", 0, 1);
        @(posedge clk); #1 cmd_valid = 0;
    endtask

    task automatic reply(input logic [7:0] d, input int dly);
        repeat (dly) @(posedge clk);
        #1 rx = 0;
        for (int i = 7; i >= 0; i--) begin @(posedge clk); #1 rx = d[i]; end
        @(posedge clk); #1 rx = 1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_bound", 0, 1);
    endtask

    function automatic logic [7:0] getb(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = txh[s+i];
        return b;
    endfunction

    initial begin
        int n, n1, n2, r0;
        logic [7:0] d;
        @(negedge clk);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_tx", tx, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        issue(1, 7'd2, 8'hA5, n);
        wait_idle();
        chk("wr_start", txh[n+1], 0);
        chk("wr_addr", getb(n+2), 8'h05);
        chk("wr_gap", {txh[n+10], txh[n+11]}, 2'b11);
        chk("wr_dstart", txh[n+12], 0);
        chk("wr_data", getb(n+13), 8'hA5);
        chk("wr_rsp_cycle", rsp_cyc - n, 21);
        chk("wr_err", rsp_e, 0);

        issue(0, 7'd0, 8'h00, n);
        reply(8'hDE, 12);
        wait_idle();
        chk("rd_addr", getb(n+2), 8'h00);
        chk("rd_data", rsp_d, 8'hDE);
        chk("rd_err", rsp_e, 0);
        chk("rd_rsp_cycle", rsp_cyc - n, 24);

        issue(0, 7'h11, 8'h00, n);
`ifdef ZL_UART_HOST_RDTIMEOUT_EN
        wait_idle();
        chk("to_cycle", rsp_cyc - n, 10 + T);
        chk("to_err", rsp_e, 1);
        chk("to_data", rsp_d, 0);
`else
        repeat (1000) @(negedge clk);
        chk("to_busy", busy, 1);
        reply(8'h3C, 1);
        wait_idle();
        chk("late_data", rsp_d, 8'h3C);
        chk("late_err", rsp_e, 0);
`endif

        r0 = n_rsp;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 7'h05; cmd_wdata = 8'h3C;
        n1 = -1; n2 = -1;
        for (int k = 0; k < 200 && n2 < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                if (n1 < 0) n1 = cyc; else n2 = cyc;
            end
        end
        @(posedge clk); #1 cmd_valid = 0;
        wait_idle();
        chk("b2b_spacing", n2 - n1, 20 + G);
        chk("b2b_start", txh[n2+1], 0);
        chk("b2b_rsp_count", n_rsp - r0, 2);

        r0 = n_rsp;
        issue(1, 7'h33, 8'h77, n);
        @(posedge clk); #3;
        chk("pre_rst_tx", tx, 0);
        rst_n = 0;
        #1 chk("async_rst_tx", tx, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        repeat (30) @(negedge clk);
        chk("rst_no_rsp", n_rsp - r0, 0);

        @(posedge clk); #1 rx = 0;
        @(posedge clk); #1 rx = 1;
        issue(1, 7'd4, 8'h99, n);
        repeat (2) @(posedge clk);
        #1 rx = 0;
        @(posedge clk); #1 rx = 1;
        repeat (6) @(posedge clk);
        #1 rx = 0;
        @(posedge clk); #1 rx = 1;
        wait_idle();
        chk("glitch_wr_err", rsp_e, 0);
        issue(0, 7'd4, 8'h00, n);
        reply(8'h5A, 11);
        wait_idle();
        chk("glitch_rd_data", rsp_d, 8'h5A);

        for (int t = 0; t < 40; t++) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            issue(w, 7'($urandom), 8'($urandom), n);
            if (!w) reply(d, 9 + $urandom_range(0, 8));
            wait_idle();
            if (!w) chk("rand_rd_data", rsp_d, d);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/zl_uart_host.md
# zl_uart_host

Host-side initiator for the single-wire-per-direction register link served by the `zl_uart` responder. It accepts register read/write commands on a valid/ready interface and serializes an address frame on `tx`. For writes it follows with a data frame; for reads it deserializes the reply from `rx`. It sits in the host/test-controller chip or FPGA and runs on the same clock as the link, at one bit per clock.

## Interface
- `GAP_CYCLES`, default 2: idle-high cycles between the address-frame LSB and the write data start bit. Legal range is 1..200.
- `RD_TIMEOUT`, default 32: cycles spent waiting for a read-reply start bit before giving up. Legal range is 2..255.
- `clk` in 1: link clock, one bit per cycle.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE. Combinational from state.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 7: register address.
- `cmd_wdata` in 8: write data. Ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse, issued for writes and reads alike.
- `rsp_rdata` out 8: read data. Reads as 0 for writes and on error. Held until the next `rsp_valid`.
- `rsp_err` out 1: read timeout. Qualified by `rsp_valid`.
- `busy` out 1: high when not in IDLE.
- `tx` out 1: serial out, idle high, registered.
- `rx` in 1: serial in from the responder, asynchronous.

## Operation
- Frame format: start bit 0, then 8 bits MSB first. There is no parity. The line stays high when idle.
- Address byte is {`cmd_addr`, `cmd_write``}, so bit 0 is the R/W flag.
- A command is accepted on `cmd_valid & cmd_ready`. Addr, wdata and write are latched at acceptance.
- States and transitions:
  - IDLE: on accept, go to ADDR.
  - ADDR: 9 bit-times (start + 8). When done, go to GAP if write, or RWAIT if read.
  - GAP: `tx`=1 for `GAP_CYCLES`, then go to WDATA.
  - WDATA: 9 bit-times, then go to STOP.
  - STOP: `tx`=1 for one cycle, `rsp_valid`=1, then go to IDLE.
  - RWAIT: `tx`=1. The first cycle with synchronized rx = 0 is the start bit; go to RDATA.
  - RDATA: sample synchronized rx for 8 consecutive cycles, MSB first, then go to RESP.
  - RESP: `rsp_valid`=1, then go to IDLE.
- `rx` passes through a 2-flop synchronizer. Low levels on `rx` outside RWAIT are ignored.
- A 4-bit bit counter runs in ADDR, WDATA and RDATA. An 8-bit wait counter runs in GAP and RWAIT.
- `cmd_valid` while busy is not accepted. The command stays pending until `cmd_ready` is high.
- Reset values: `tx`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, state=IDLE, so `cmd_ready`=1.
- Reset mid-operation: `tx` goes to 1 immediately (asynchronous). The transaction is abandoned and no `rsp_valid` is issued for it.

## Timing
Command accepted in cycle N:
- `tx`=0 (start bit) in N+1.
- Address bits 7..0 in N+2..N+9.
- Write path:
  - `tx`=1 in N+10..N+9+`GAP_CYCLES`.
  - Data start bit in N+10+G, data bits in N+11+G..N+18+G.
  - Stop and `rsp_valid` in N+19+G (N+21 for G=2).
  - `cmd_ready`=1 in N+20+G.
- Read path:
  - RWAIT begins in N+10.
  - If synchronized rx is first 0 in cycle S, data bits are sampled in S+1..S+8.
  - `rsp_valid` with `rsp_rdata` occurs in S+9.
  - `cmd_ready`=1 in S+10.
- Back-to-back operation: a new command can be accepted in the first cycle `cmd_ready` is high.

## Configuration
- `ZL_UART_HOST_RDTIMEOUT_EN` defined: after `RD_TIMEOUT` RWAIT cycles with no start bit, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- `ZL_UART_HOST_RDTIMEOUT_EN` undefined: RWAIT waits indefinitely for a start bit, the RWAIT timeout counter is removed, and `rsp_err` is tied to 0.

## Structure
- Package `zl_uart_pkg` holds:
  - the state enum;
  - `FRAME_BITS`=8 and the R/W bit position;
  - responder register map: SIG_HI=0, SIG_LO=1, SCRATCH=2, LED=3, INPUT=4;
  - signature 16'hDEDA.
- One sub-module, `zl_sync2`: the 2-flop synchronizer for `rx`, reset to 1.

## Test plan
- Write addr 2, data 0xA5, G=2: `tx` shows 0, then 0x05 MSB first, high, high, 0, then 0xA5 MSB first. `rsp_valid` in N+21 with err=0.
- Read addr 0 against a responder model replying 0xDE after 3 idle cycles: `tx` sends address byte 0x00. Result is `rsp_rdata`=0xDE, err=0.
- Read with `rx` held high:
  - macro defined: `rsp_valid` with err=1 and rdata=0 exactly `RD_TIMEOUT` cycles into RWAIT;
  - macro undefined: `busy` stays 1 for 1000 cycles, then a late 0x3C reply completes normally.
- `cmd_valid` held through a whole write: exactly one acceptance per IDLE visit. The second command starts its start bit in the cycle after the first `cmd_ready` reassertion.
- `rst_n` pulsed low mid-ADDR: `tx`=1 asynchronously, no `rsp_valid`, and `cmd_ready`=1 after release.
- `rx` pulses low during IDLE, ADDR and GAP: no effect. A subsequent read still returns the correct 0x5A.
